// File: rtl/ov7670_pattern_tx.sv
// OV7670-style parallel pixel source: pclk/vsync/href plus RGB565 test patterns,
// two bytes per pixel, high byte first. All timing advances on pclk falling edges.
module ov7670_pattern_tx #(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);
    localparam int LINE = 2*H_ACTIVE + H_BLANK;
    localparam int HW   = $clog2(LINE);
    localparam int VM1  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int LW   = $clog2(VMAX + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE - 1);
    localparam logic [HW-1:0] H_ACT2     = HW'(2*H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(2*H_ACTIVE - 1);
    localparam logic [LW-1:0] L_VS       = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_VB       = LW'(V_BACK - 1);
    localparam logic [LW-1:0] L_VA       = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] L_VF       = LW'(V_FRONT - 1);
    localparam logic [15:0]   BAR_LAST   = 16'(H_ACTIVE/8 - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t        state, nxt_state;
    logic [HW-1:0] h, nxt_h;
    logic [LW-1:0] ln, nxt_ln, ln_last;
    logic          line_end, frame_end, frame_start, nxt_act;
    logic [1:0]    mode_q;
    logic [7:0]    x;
    logic [3:0]    y;
    logic [2:0]    bar;
    logic [15:0]   bar_cnt, addr, pix_w;
    logic [7:0]    pix_lo;

    always_comb begin
        case (state)
            VSYNC:   ln_last = L_VS;
            VBACK:   ln_last = L_VB;
            ACTIVE:  ln_last = L_VA;
            VFRONT:  ln_last = L_VF;
            default: ln_last = '0;
        endcase
    end

    // Position of the slot that the next slot edge will present.
    always_comb begin
        line_end  = (h == H_LAST);
        nxt_state = state;
        nxt_h     = h + 1'b1;
        nxt_ln    = ln;
        frame_end = 1'b0;
        if (state == IDLE) begin
            nxt_h = '0;
            if (enable) nxt_state = VSYNC;
        end else if (line_end) begin
            nxt_h  = '0;
            nxt_ln = ln + 1'b1;
            if (ln == ln_last) begin
                nxt_ln = '0;
                case (state)
                    VSYNC:  nxt_state = VBACK;
                    VBACK:  nxt_state = ACTIVE;
                    ACTIVE: nxt_state = VFRONT;
                    default: begin
                        frame_end = 1'b1;
                        nxt_state = enable ? VSYNC : IDLE;
                    end
                endcase
            end
        end
        frame_start = (nxt_state == VSYNC) && ((state == IDLE) || frame_end);
        nxt_act     = (nxt_state == ACTIVE) && (nxt_h < H_ACT2);
    end

    always_comb begin
        case (mode_q)
            2'd0: begin
                case (bar)
                    3'd0:    pix_w = 16'hFFFF;
                    3'd1:    pix_w = 16'hFFE0;
                    3'd2:    pix_w = 16'h07FF;
                    3'd3:    pix_w = 16'h07E0;
                    3'd4:    pix_w = 16'hF81F;
                    3'd5:    pix_w = 16'hF800;
                    3'd6:    pix_w = 16'h001F;
                    default: pix_w = 16'h0000;
                endcase
            end
            2'd1:    pix_w = {x[7:3], x[7:2], x[7:3]};
            2'd2:    pix_w = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: pix_w = addr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk        <= 1'b0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            d           <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
            h           <= '0;
            ln          <= '0;
            mode_q      <= '0;
            x           <= '0;
            y           <= '0;
            bar         <= '0;
            bar_cnt     <= '0;
            addr        <= '0;
            pix_lo      <= '0;
        end else begin
            pclk       <= ~pclk;
            frame_done <= 1'b0;
            if (pclk) begin
                state <= nxt_state;
                h     <= nxt_h;
                ln    <= nxt_ln;
                vsync <= (nxt_state == VSYNC);
                href  <= nxt_act;
                busy  <= (nxt_state != IDLE);
                d     <= '0;
                if (frame_end) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end
                if (frame_start) begin
                    mode_q <= mode;
                    y      <= '0;
                    addr   <= '0;
                end
                if (nxt_act) begin
                    if (!nxt_h[0]) begin
                        d      <= pix_w[15:8];
                        pix_lo <= pix_w[7:0];
                        x      <= x + 8'd1;
                        addr   <= addr + 16'd1;
                        if (bar_cnt == BAR_LAST) begin
                            bar_cnt <= '0;
                            bar     <= bar + 1'b1;
                        end else begin
                            bar_cnt <= bar_cnt + 16'd1;
                        end
                    end else begin
                        d <= pix_lo;
                    end
                end
                // Rewind the line generators while leaving the last active byte,
                // so the next line's first pixel never sees stale x/bar.
                if (state == ACTIVE && h == H_ACT_LAST) begin
                    x       <= '0;
                    bar     <= '0;
                    bar_cnt <= '0;
                    y       <= y + 4'd1;
                end
            end
        end
    end
endmodule
